// File: rtl/ff_pkg.sv
// rtl/ff_pkg.sv - shared states, constants and averaging helper for the analog stick ADC
package ff_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } adc_state_t;

  localparam int         ADC_NCH    = 4;
  localparam logic [7:0] ADC_UNUSED = 8'hFF;
  localparam logic [7:0] ADC_CENTRE = 8'h80;

  // Rounded mean of two levels; the 9-bit sum keeps the carry before the shift.
  function automatic logic [7:0] adc_avg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b} + 9'd1;
    return sum[8:1];
  endfunction

endpackage

// File: rtl/adc_ce_div.sv
// rtl/adc_ce_div.sv - free-running MCLK divider producing a one-cycle converter TICK
module adc_ce_div
  import ff_pkg::*;
#(
  parameter int CLK_DIV = 75
) (
  input  logic MCLK,
  input  logic RESET,
  output logic TICK
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          wrap;

  // Next count and tick: TICK is high in the cycle where the count sits at 0.
  always_comb begin
    wrap   = (cnt_q == CW'(CLK_DIV - 1));
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    tick_d = wrap;
  end

  // Divider state registers.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign TICK = tick_q;

endmodule

// File: rtl/analog_adc.sv
// rtl/analog_adc.sv - four-channel stick ADC model; ANALOG_ADC_FILTER_EN adds a 2-tap per-channel filter
module analog_adc
  import ff_pkg::*;
#(
  parameter int CLK_DIV    = 75,
  parameter int CONV_TICKS = 64
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic [7:0] AX0,
  input  logic [7:0] AY0,
  input  logic [7:0] AX1,
  input  logic [7:0] AY1,
  input  logic [2:0] CH,
  input  logic       START,
  input  logic       RD,
  output logic [7:0] DOUT,
  output logic       EOC,
  output logic       BUSY
);

  localparam int TW = (CONV_TICKS > 1) ? $clog2(CONV_TICKS) : 1;

  logic          tick;
  adc_state_t    state_q, state_d;
  logic [2:0]    ch_q, ch_d;
  logic [7:0]    sample_q, sample_d;
  logic [TW-1:0] conv_cnt_q, conv_cnt_d;
  logic [7:0]    dout_q, dout_d;
  logic          eoc_q, eoc_d;
  logic          busy_q, busy_d;
  logic [7:0]    level;
  logic [7:0]    result;

  adc_ce_div #(.CLK_DIV(CLK_DIV)) u_div (
    .MCLK  (MCLK),
    .RESET (RESET),
    .TICK  (tick)
  );

  // Input selected by the latched channel; unpopulated channels read full scale.
  always_comb begin
    case (ch_q)
      3'd0:    level = AX0;
      3'd1:    level = AY0;
      3'd2:    level = AX1;
      3'd3:    level = AY1;
      default: level = ADC_UNUSED;
    endcase
  end

`ifdef ANALOG_ADC_FILTER_EN
  logic [7:0] hist_q [ADC_NCH];

  // Filtered result: average of the previous sample of this channel and the new one.
  always_comb begin
    result = ch_q[2] ? sample_q : adc_avg(hist_q[ch_q[1:0]], sample_q);
  end

  // History takes the new sample on the cycle EOC rises; aborted conversions leave it alone.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < ADC_NCH; i++) hist_q[i] <= ADC_CENTRE;
    end else if (eoc_d && !eoc_q && !ch_q[2]) begin
      hist_q[ch_q[1:0]] <= sample_q;
    end
  end
`else
  assign result = sample_q;
`endif

  // Conversion sequencing: START always restarts, otherwise advance on TICK.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    sample_d   = sample_q;
    conv_cnt_d = conv_cnt_q;
    dout_d     = dout_q;
    eoc_d      = eoc_q;
    if (START) begin
      state_d    = SAMPLE;
      ch_d       = CH;
      eoc_d      = 1'b0;
      conv_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: ;
        SAMPLE: begin
          if (tick) begin
            sample_d   = level;
            conv_cnt_d = '0;
            state_d    = CONVERT;
          end
        end
        CONVERT: begin
          if (tick) begin
            if (conv_cnt_q == TW'(CONV_TICKS - 1)) begin
              dout_d  = result;
              eoc_d   = 1'b1;
              state_d = DONE;
            end else begin
              conv_cnt_d = conv_cnt_q + TW'(1);
            end
          end
        end
        DONE: begin
          if (RD) begin
            eoc_d   = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == SAMPLE) || (state_d == CONVERT);
  end

  // State machine and registered outputs.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      ch_q       <= 3'd0;
      sample_q   <= 8'h00;
      conv_cnt_q <= '0;
      dout_q     <= 8'h00;
      eoc_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      sample_q   <= sample_d;
      conv_cnt_q <= conv_cnt_d;
      dout_q     <= dout_d;
      eoc_q      <= eoc_d;
      busy_q     <= busy_d;
    end
  end

  assign DOUT = dout_q;
  assign EOC  = eoc_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_analog_adc.sv
// tb/tb_analog_adc.sv - randomized self-checking bench for analog_adc with a behavioural model
module tb_analog_adc;

  localparam int D = 10;
  localparam int T = 64;

  logic       MCLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] AX0 = 8'h80, AY0 = 8'h80, AX1 = 8'h80, AY1 = 8'h80;
  logic [2:0] CH = 3'd0;
  logic       START = 1'b0;
  logic       RD = 1'b0;
  logic [7:0] DOUT;
  logic       EOC;
  logic       BUSY;

  analog_adc #(.CLK_DIV(D), .CONV_TICKS(T)) dut (
    .MCLK  (MCLK),
    .RESET (RESET),
    .AX0   (AX0),
    .AY0   (AY0),
    .AX1   (AX1),
    .AY1   (AY1),
    .CH    (CH),
    .START (START),
    .RD    (RD),
    .DOUT  (DOUT),
    .EOC   (EOC),
    .BUSY  (BUSY)
  );

  always #5 MCLK = ~MCLK;

  // MCLK edges since reset release; edge 1 is the first edge after RESET falls.
  int edge_n = 0;
  always @(posedge MCLK) begin
    if (RESET) edge_n = 0;
    else       edge_n = edge_n + 1;
  end

  int n_chk = 0;
  int n_pass = 0;
  int hist [4];
  int prev_res = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  // Edge at which EOC is expected: ticks act on edges k*D+1, the first one after
  // START captures the sample and T further ticks finish the conversion.
  function automatic int eoc_edge(input int s);
    return ((s - 1) / D) * D + D + 1 + T * D;
  endfunction

  function automatic int level_of(input int ch);
    case (ch)
      0: return int'(AX0);
      1: return int'(AY0);
      2: return int'(AX1);
      3: return int'(AY1);
      default: return 255;
    endcase
  endfunction

  task automatic model_result(input int ch, input int smp, output int res);
    if (ch >= 4) begin
      res = 255;
    end else begin
`ifdef ANALOG_ADC_FILTER_EN
      res = (hist[ch] + smp + 1) / 2;
      hist[ch] = smp;
`else
      res = smp;
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge MCLK);
    RESET = 1'b1;
    START = 1'b0;
    RD = 1'b0;
    @(negedge MCLK);
    @(negedge MCLK);
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) hist[i] = 128;
    prev_res = 0;
  endtask

  task automatic start_conv(input int ch, output int s);
    @(negedge MCLK);
    CH = 3'(ch);
    START = 1'b1;
    @(negedge MCLK);
    START = 1'b0;
    s = edge_n;
  endtask

  task automatic wait_eoc(output int at);
    at = -1;
    for (int i = 0; i < (T + 3) * D && at < 0; i++) begin
      @(negedge MCLK);
      if (EOC) at = edge_n;
    end
  endtask

  task automatic rd_pulse();
    @(negedge MCLK);
    RD = 1'b1;
    @(negedge MCLK);
    RD = 1'b0;
  endtask

  task automatic randomize_inputs();
    AX0 = 8'($urandom);
    AY0 = 8'($urandom);
    AX1 = 8'($urandom);
    AY1 = 8'($urandom);
  endtask

  int s, at, r, ch, smp;

  initial begin
    do_reset();
    chk("reset_dout", int'(DOUT), 0);
    chk("reset_eoc", int'(EOC), 0);
    chk("reset_busy", int'(BUSY), 0);

    // Channel 0 basic conversion, straight after reset.
    AX0 = 8'h3C;
    start_conv(0, s);
    chk("ch0_busy_start", int'(BUSY), 1);
    chk("ch0_eoc_start", int'(EOC), 0);
    wait_eoc(at);
    chk("ch0_latency", at, eoc_edge(s));
    model_result(0, 'h3C, r);
    chk("ch0_dout", int'(DOUT), r);
    chk("ch0_busy_done", int'(BUSY), 0);
    rd_pulse();
    @(negedge MCLK);
    chk("ch0_eoc_rd", int'(EOC), 0);
    chk("ch0_dout_hold", int'(DOUT), r);
    prev_res = r;

    // Unpopulated channel.
    start_conv(5, s);
    chk("ch5_dout_hold", int'(DOUT), prev_res);
    wait_eoc(at);
    chk("ch5_latency", at, eoc_edge(s));
    model_result(5, 0, r);
    chk("ch5_dout", int'(DOUT), r);
    rd_pulse();
    prev_res = r;

    // Restart mid-conversion: only the second conversion completes.
    AY0 = 8'h10;
    AX1 = 8'hE0;
    start_conv(1, s);
    repeat (30 * D) @(negedge MCLK);
    chk("abort_no_eoc", int'(EOC), 0);
    start_conv(2, s);
    wait_eoc(at);
    chk("abort_latency", at, eoc_edge(s));
    model_result(2, 'hE0, r);
    chk("abort_dout", int'(DOUT), r);
    prev_res = r;

    // RD and START together while EOC is high: START wins.
    chk("both_eoc_before", int'(EOC), 1);
    @(negedge MCLK);
    AY1 = 8'h77;
    CH = 3'd3;
    RD = 1'b1;
    START = 1'b1;
    @(negedge MCLK);
    RD = 1'b0;
    START = 1'b0;
    s = edge_n;
    chk("both_eoc", int'(EOC), 0);
    chk("both_busy", int'(BUSY), 1);
    wait_eoc(at);
    chk("both_latency", at, eoc_edge(s));
    model_result(3, 'h77, r);
    chk("both_dout", int'(DOUT), r);
    rd_pulse();

    // Reset in the middle of a conversion.
    start_conv(1, s);
    repeat (40 * D) @(negedge MCLK);
    do_reset();
    chk("rst_mid_eoc", int'(EOC), 0);
    chk("rst_mid_dout", int'(DOUT), 0);
    chk("rst_mid_busy", int'(BUSY), 0);
    wait_eoc(at);
    chk("rst_mid_no_eoc", at, -1);

    // Randomized conversions, inputs scrambled once the sample is taken.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2 * D)) @(negedge MCLK);
      randomize_inputs();
      ch = int'($urandom_range(0, 7));
      smp = level_of(ch);
      start_conv(ch, s);
      chk("rnd_dout_hold", int'(DOUT), prev_res);
      repeat (2 * D) @(negedge MCLK);
      randomize_inputs();
      wait_eoc(at);
      chk("rnd_latency", at, eoc_edge(s));
      model_result(ch, smp, r);
      chk("rnd_dout", int'(DOUT), r);
      chk("rnd_busy", int'(BUSY), 0);
      prev_res = r;
      if ($urandom_range(0, 1) == 1) begin
        rd_pulse();
        @(negedge MCLK);
        chk("rnd_eoc_rd", int'(EOC), 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/analog_adc.md
ANALOG_ADC -- requirements
Module: analog_adc

Interface
REQ-001 Parameter CLK_DIV, default 75, MCLK cycles per converter tick (48 MHz / 75 = 640 kHz).
REQ-002 Parameter CONV_TICKS, default 64, converter ticks from start to end-of-conversion.
REQ-003 MCLK  input  1  system clock; all logic on rising edge.
REQ-004 RESET  input  1  reset, asynchronous, active-high.
REQ-005 AX0, AY0, AX1, AY1  input  8 each  analog stick levels for channels 0..3, unsigned, 0x80 = centre.
REQ-006 CH  input  3  channel select, captured on START.
REQ-007 START  input  1  one-MCLK CPU write strobe that latches CH and begins conversion.
REQ-008 RD  input  1  one-MCLK CPU read strobe that clears EOC.
REQ-009 DOUT  output  8  last conversion result, held stable until the next result.
REQ-010 EOC  output  1  conversion complete flag.
REQ-011 BUSY  output  1  high while the state is SAMPLE or CONVERT.

Function
REQ-012 Free-running tick divider counts 0..CLK_DIV-1 and pulses TICK for one MCLK when the count wraps to 0.
REQ-013 The state machine has four states: IDLE, SAMPLE, CONVERT and DONE.
REQ-014 START in any state: latch CH, clear EOC, reset the tick counter of the conversion and enter SAMPLE on the next MCLK; a START during a conversion aborts it and restarts.
REQ-015 SAMPLE: on the next TICK, capture the selected input into the sample register and enter CONVERT.
REQ-016 CONVERT: count TICKs; on TICK number CONV_TICKS-1, load DOUT from the sample register, set EOC and enter DONE in the same MCLK.
REQ-017 Latency from START to EOC is CONV_TICKS+1 TICKs, ±1 TICK of divider phase.
REQ-018 DONE: RD clears EOC and returns to IDLE; DOUT is unchanged.
REQ-019 A simultaneous START and RD: START wins and EOC is cleared.
REQ-020 Channels 4..7 convert to 0xFF.
REQ-021 Inputs are sampled only in SAMPLE; changes during CONVERT do not affect the result.
REQ-022 Tick counters wrap modulo their width and never overflow past CONV_TICKS-1.

Reset
REQ-023 RESET asserted: state = IDLE, DOUT = 0x00, EOC = 0, BUSY = 0, divider = 0, latched channel = 0, filter history = 0x80.
REQ-024 RESET mid-conversion aborts it; no EOC is produced for the aborted conversion.
REQ-025 After RESET deasserts, the first TICK occurs CLK_DIV MCLKs later.

Configuration
REQ-026 Macro ANALOG_ADC_FILTER_EN defined: each channel 0..3 keeps an 8-bit history register.
- Result = (history + sample + 1) >> 1, computed 9-bit and truncated to 8 bits.
- History is updated to the new sample at EOC.
REQ-027 ANALOG_ADC_FILTER_EN undefined: DOUT = raw sample; no history registers are synthesised.

Structure
REQ-028 Shared package ff_pkg holds:
- state enum adc_state_t {IDLE, SAMPLE, CONVERT, DONE};
- constants ADC_NCH = 4, ADC_UNUSED = 8'hFF, ADC_CENTRE = 8'h80.
REQ-029 The tick divider is a separate sub-module adc_ce_div (parameter CLK_DIV, ports MCLK, RESET, TICK).
REQ-030 The remaining logic stays in analog_adc.

Verification
REQ-031 AX0 = 0x3C, CH = 0, START → EOC rises after 65±1 TICKs; DOUT = 0x3C; BUSY low afterwards.
REQ-032 CH = 5, START → DOUT = 0xFF at EOC.
REQ-033 START CH = 1 (AY0 = 0x10); at TICK 30, START CH = 2 (AX1 = 0xE0) → exactly one EOC, at 65 TICKs after the second START; DOUT = 0xE0.
REQ-034 EOC high, then RD and START on the same MCLK → EOC = 0 and BUSY = 1 on the next MCLK.
REQ-035 RESET pulse at TICK 40 of a conversion → no EOC; DOUT = 0x00; state = IDLE.
REQ-036 With ANALOG_ADC_FILTER_EN: AX0 = 0xFF, two conversions of CH 0 after reset → DOUT = 0xC0, then 0xFF.
